adia_pclk_seq: RTL and testbench
================================

Name: adia_pclk_seq

Overview:
- Digital sequencer for the 4-phase power clocks (clkpos/clkneg pairs) that drive a chain of NSTAGES adiabatic ALU stages (mux/gate cells).
- Accepts operations through a valid/ready handshake and wakes each stage's power clock in phase order.
- Tracks in-flight operation tags and pulses completion when the last stage holds its result.
- Parks every power clock low when the pipeline is empty.

Parameters:
- NSTAGES, 4, number of adiabatic stages sequenced (1..16).
- PHASE_CYC, 4, clk cycles per power-clock phase (>=2).
- TAG_W, 4, width of the operation tag carried alongside each op.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  op request.
- in_ready  out  1  op can be accepted this cycle.
- in_tag  in  TAG_W  tag of the requested op.
- pc_phase  out  2*NSTAGES  per-stage phase code; stage k uses bits [2k+1:2k].
- pc_en  out  NSTAGES  stage k power clock awake; when 0, the driver holds clkpos low and clkneg high.
- out_valid  out  1  one-cycle completion pulse (no backpressure: adiabatic ramps cannot stall).
- out_tag  out  TAG_W  tag of the completing op; valid with out_valid.

Behaviour:
- Phase codes: 0 RAMP_UP, 1 HOLD, 2 RAMP_DOWN, 3 IDLE. An asleep stage always outputs code 3.
- Timer:
  - cnt counts 0..PHASE_CYC-1; tick = (cnt==PHASE_CYC-1).
  - ph (0..3) increments mod 4 on tick.
  - Awake stage k code = (ph-k) mod 4.
- FSM states:
  - IDLE: cnt=0, ph=0, all asleep.
  - RUN
  - DRAIN
- in_ready = (state==IDLE) | (state==RUN & tick & ph==3). It is 0 in DRAIN.
- Accept = in_valid & in_ready. It loads v[0]=1 and tag[0]=in_tag for the next phase.
- From IDLE, accept moves to RUN with cnt=0, ph=0 and stage 0 awake.
- Occupancy: v[0..NSTAGES] with tags; shifts by one on every tick. v[0] is loaded with the accept result of that tick.
- out_valid=1 and out_tag=tag[NSTAGES] on the tick cycle while v[NSTAGES]=1. Latency = (NSTAGES+1)*PHASE_CYC cycles after the accepting edge. Max throughput is one op per 4 phases.
- Wake rule (RUN): an asleep stage becomes awake on the tick where its next code is 0.
- RUN -> DRAIN: on a tick with ph==3, no accept, and v[0..NSTAGES] all zero after the shift.
- Sleep rule (on the DRAIN-entry tick and every DRAIN tick): a stage whose next code is 0 or 3 goes asleep.
- DRAIN -> IDLE: once all stages are asleep. cnt and ph are cleared.
- No stage ever enters RAMP_DOWN without a preceding RAMP_UP/HOLD, and none re-enters RAMP_UP in DRAIN.
- Reset (including mid-op):
  - state=IDLE, cnt=0, ph=0, v=0, tags=0, all asleep.
  - pc_phase all 3, pc_en=0, out_valid=0, out_tag=0, in_ready=1.
  - In-flight ops are dropped without completion.
- in_valid held during DRAIN is accepted from IDLE on the cycle after DRAIN exits.

Optional Feature:
- Macro ADIA_PERF_CNT_EN.
- When defined, add outputs op_count (16b) and active_cycles (32b):
  - op_count increments on out_valid and saturates at 0xFFFF.
  - active_cycles counts cycles with state!=IDLE and saturates.
  - Both clear on rst.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package adia_pkg:
  - phase_e enum (RAMP_UP=0, HOLD=1, RAMP_DOWN=2, IDLE_PH=3)
  - seq_state_e (S_IDLE, S_RUN, S_DRAIN)
  - localparam PHASES=4
- Sub-module adia_phase_timer: owns cnt/ph/tick, has a clear input, takes the PHASE_CYC parameter.

Test Plan:
- Defaults; rst, then in_valid with tag 0x5, accepted at edge 0:
  - stage0 codes 0/1/2/3 in cycles 1-4/5-8/9-12/13-16
  - stage1 code 3 with pc_en=0 in cycles 1-4, then 0 in cycles 5-8
  - out_valid with out_tag=5 at cycle 20 only
- in_valid held with tags 1,2,3 -> accepts at cycles 0, 16, 32; in_ready low elsewhere; out_valid at cycles 20, 36, 52 with tags 1,2,3.
- Single op at cycle 0, in_valid then low -> DRAIN entered at the cycle-32 tick:
  - stage0 sleeps immediately; stage3 ramps down in cycles 37-40
  - all pc_en=0 and state IDLE from cycle 41; in_ready=0 in cycles 33-40
- Reset asserted at cycle 10 with an op in flight -> at cycle 11 pc_phase all 3, pc_en=0, in_ready=1; no out_valid ever follows for that tag.
- NSTAGES=1, PHASE_CYC=2, op at cycle 0 -> out_valid at cycle 4; DRAIN entered at the cycle-8 tick, stage0 sleeps immediately; IDLE from cycle 9.
- ADIA_PERF_CNT_EN defined, 3 ops from test 2 -> op_count=3 after cycle 52; active_cycles equals the non-IDLE cycle count.

Source files
------------

// File: rtl/adia_pkg.sv
// Shared types for the adiabatic power-clock sequencer: phase codes, FSM states
// and the per-stage phase-offset helper.
package adia_pkg;

  localparam int unsigned PHASES = 4;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD      = 2'd1,
    RAMP_DOWN = 2'd2,
    IDLE_PH   = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } seq_state_e;

  // Stage k lags the global phase by k (mod 4).
  function automatic phase_e stage_code(input logic [1:0] ph, input int unsigned k);
    logic [1:0] kk;
    kk = k[1:0];
    return phase_e'(ph - kk);
  endfunction

endpackage

// File: rtl/adia_phase_timer.sv
// Power-clock phase timer: cnt runs 0..PHASE_CYC-1, ph advances mod 4 on tick.
// clr_i parks both counters at zero.
module adia_phase_timer #(
  parameter int unsigned PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  output logic [1:0] ph_o,
  output logic       tick_o
);

  localparam int unsigned CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ph_q, ph_d;

  always_comb begin
    tick_o = (cnt_q == CW'(PHASE_CYC - 1));
    cnt_d  = cnt_q + CW'(1);
    ph_d   = ph_q;
    if (clr_i) begin
      cnt_d = '0;
      ph_d  = '0;
    end else if (tick_o) begin
      cnt_d = '0;
      ph_d  = ph_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ph_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  assign ph_o = ph_q;

endmodule

// File: rtl/adia_pclk_seq.sv
// 4-phase power-clock sequencer for a chain of NSTAGES adiabatic stages.
// Optional perf counters (op_count, active_cycles) under ADIA_PERF_CNT_EN.
module adia_pclk_seq
  import adia_pkg::*;
#(
  parameter int unsigned NSTAGES   = 4,
  parameter int unsigned PHASE_CYC = 4,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [2*NSTAGES-1:0] pc_phase,
  output logic [NSTAGES-1:0]   pc_en,
  output logic                 out_valid,
`ifdef ADIA_PERF_CNT_EN
  output logic [TAG_W-1:0]     out_tag,
  output logic [15:0]          op_count,
  output logic [31:0]          active_cycles
`else
  output logic [TAG_W-1:0]     out_tag
`endif
);

  seq_state_e state_q, state_d;

  logic [1:0] ph;
  logic       tick;
  logic       tmr_clr;

  logic [NSTAGES:0]   v_q, v_d;
  logic [TAG_W-1:0]   tag_q [NSTAGES+1];
  logic [TAG_W-1:0]   tag_d [NSTAGES+1];
  logic [NSTAGES-1:0] en_q, en_d, wake_m, sleep_m, en_slept;

  logic accept, phase_end, advance;
  phase_e nc;

  assign tmr_clr = (state_q == S_IDLE) || (state_d == S_IDLE);

  adia_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .ph_o   (ph),
    .tick_o (tick)
  );

  // Wake/sleep candidates look at each stage's code for the phase after this tick.
  always_comb begin
    wake_m  = '0;
    sleep_m = '0;
    nc      = IDLE_PH;
    for (int unsigned k = 0; k < NSTAGES; k++) begin
      nc         = stage_code(ph + 2'd1, k);
      wake_m[k]  = (nc == RAMP_UP);
      sleep_m[k] = (nc == RAMP_UP) || (nc == IDLE_PH);
    end
    en_slept = en_q & ~sleep_m;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN: begin
        if (phase_end && !accept && (v_q[NSTAGES-1:0] == '0))
          state_d = (en_slept == '0) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: if (tick && (en_slept == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    phase_end = (state_q == S_RUN) && tick && (ph == 2'(PHASES - 1));
    in_ready  = (state_q == S_IDLE) || phase_end;
    accept    = in_valid && in_ready;
    out_valid = (state_q != S_IDLE) && tick && v_q[NSTAGES];
    out_tag   = out_valid ? tag_q[NSTAGES] : '0;
    pc_en     = en_q;
    pc_phase  = '1;
    for (int unsigned k = 0; k < NSTAGES; k++)
      pc_phase[2*k +: 2] = en_q[k] ? stage_code(ph, k) : IDLE_PH;
  end

  // Occupancy shifts once per phase; an accept from IDLE loads slot 0 off-tick.
  always_comb begin
    advance = accept || ((state_q != S_IDLE) && tick);
    v_d     = v_q;
    tag_d   = tag_q;
    en_d    = en_q;
    if (advance) begin
      v_d      = {v_q[NSTAGES-1:0], accept};
      tag_d[0] = accept ? in_tag : '0;
      for (int unsigned i = 1; i <= NSTAGES; i++) tag_d[i] = tag_q[i-1];
    end
    case (state_q)
      S_IDLE: if (accept) begin
        en_d    = '0;
        en_d[0] = 1'b1;
      end
      S_RUN:   if (tick) en_d = (state_d == S_RUN) ? (en_q | wake_m) : en_slept;
      S_DRAIN: if (tick) en_d = en_slept;
      default: en_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      en_q <= '0;
      for (int unsigned i = 0; i <= NSTAGES; i++) tag_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      en_q  <= en_d;
      tag_q <= tag_d;
    end
  end

`ifdef ADIA_PERF_CNT_EN
  logic [15:0] opc_q;
  logic [31:0] act_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q <= '0;
      act_q <= '0;
    end else begin
      if (out_valid && (opc_q != '1))             opc_q <= opc_q + 16'd1;
      if ((state_q != S_IDLE) && (act_q != '1))   act_q <= act_q + 32'd1;
    end
  end

  assign op_count      = opc_q;
  assign active_cycles = act_q;
`else
`endif

endmodule

// File: tb/tb_adia_pclk_seq.sv
// Directed self-checking bench for adia_pclk_seq (default config plus a
// NSTAGES=1 / PHASE_CYC=2 instance). Cycle N is the clock period ending at edge N.
module tb_adia_pclk_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid;
  logic [3:0] in_tag, out_tag, pc_en;
  logic [7:0] pc_phase;

  logic       rst1, in_valid1, in_ready1, out_valid1;
  logic [3:0] in_tag1, out_tag1;
  logic [1:0] pc_phase1;
  logic [0:0] pc_en1;

`ifdef ADIA_PERF_CNT_EN
  logic [15:0] op_count, op_count1;
  logic [31:0] active_cycles, active_cycles1;
`endif

  adia_pclk_seq #(.NSTAGES(4), .PHASE_CYC(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .pc_phase(pc_phase), .pc_en(pc_en), .out_valid(out_valid),
`ifdef ADIA_PERF_CNT_EN
    .out_tag(out_tag), .op_count(op_count), .active_cycles(active_cycles)
`else
    .out_tag(out_tag)
`endif
  );

  adia_pclk_seq #(.NSTAGES(1), .PHASE_CYC(2), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1), .in_tag(in_tag1),
    .pc_phase(pc_phase1), .pc_en(pc_en1), .out_valid(out_valid1),
`ifdef ADIA_PERF_CNT_EN
    .out_tag(out_tag1), .op_count(op_count1), .active_cycles(active_cycles1)
`else
    .out_tag(out_tag1)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int pulses;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", name, cyc, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_tag = '0;
    rst1 = 1'b1; in_valid1 = 1'b0; in_tag1 = '0;
    next(); next();

    chk("rst_phase", 32'(pc_phase), 32'hFF);
    chk("rst_en", 32'(pc_en), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_oval", 32'(out_valid), 32'h0);
    chk("rst_otag", 32'(out_tag), 32'h0);

    // Single op tag 5, then drain back to IDLE.
    rst = 1'b0; in_valid = 1'b1; in_tag = 4'h5; cyc = 0;
    chk("t1_ready0", 32'(in_ready), 32'h1);
    next();
    in_valid = 1'b0; in_tag = '0;
    for (int c = 1; c <= 44; c++) begin
      chk("t1_oval", 32'(out_valid), 32'(cyc == 20));
      if (cyc == 20) chk("t1_otag", 32'(out_tag), 32'h5);
      if (cyc <= 16) chk("t1_s0code", 32'(pc_phase[1:0]), 32'((cyc - 1) / 4));
      if (cyc <= 8) begin
        chk("t1_s1en", 32'(pc_en[1]), 32'(cyc > 4));
        chk("t1_s1code", 32'(pc_phase[3:2]), (cyc <= 4) ? 32'd3 : 32'd0);
      end
      chk("t1_ready", 32'(in_ready), 32'(cyc == 16 || cyc == 32 || cyc >= 41));
      if (cyc >= 33 && cyc <= 40) begin
        chk("t3_s0sleep", 32'(pc_en[0]), 32'h0);
        chk("t3_s3en", 32'(pc_en[3]), 32'h1);
        chk("t3_s3code", 32'(pc_phase[7:6]), (cyc <= 36) ? 32'd1 : 32'd2);
      end
      if (cyc >= 41) begin
        chk("t3_idle_en", 32'(pc_en), 32'h0);
        chk("t3_idle_ph", 32'(pc_phase), 32'hFF);
      end
      next();
    end

    // Reset mid-flight drops the op.
    rst = 1'b1; next(); rst = 1'b0;
    cyc = 0; in_valid = 1'b1; in_tag = 4'hA;
    next();
    in_valid = 1'b0;
    while (cyc < 10) next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    chk("t4_phase", 32'(pc_phase), 32'hFF);
    chk("t4_en", 32'(pc_en), 32'h0);
    chk("t4_ready", 32'(in_ready), 32'h1);
    chk("t4_oval", 32'(out_valid), 32'h0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) pulses++;
      next();
    end
    chk("t4_nocompl", 32'(pulses), 32'h0);

    // Back-to-back ops tags 1,2,3; then tag 4 held through DRAIN.
    rst = 1'b1; next(); rst = 1'b0;
    cyc = 0; in_valid = 1'b1; in_tag = 4'h1;
    for (int c = 0; c <= 96; c++) begin
      if (cyc <= 32) chk("t2_ready", 32'(in_ready), 32'(cyc == 0 || cyc == 16 || cyc == 32));
      if (cyc >= 65 && cyc <= 73) chk("t2_drain_ready", 32'(in_ready), 32'(cyc == 73));
      if (cyc >= 1) begin
        chk("t2_oval", 32'(out_valid), 32'(cyc == 20 || cyc == 36 || cyc == 52 || cyc == 93));
        if (cyc == 20) chk("t2_otag", 32'(out_tag), 32'h1);
        if (cyc == 36) chk("t2_otag", 32'(out_tag), 32'h2);
        if (cyc == 52) chk("t2_otag", 32'(out_tag), 32'h3);
        if (cyc == 93) chk("t2_otag", 32'(out_tag), 32'h4);
      end
      if (cyc == 73) chk("t2_idle_en", 32'(pc_en), 32'h0);
      if (cyc == 74) chk("t2_wake_en", 32'(pc_en), 32'h1);
`ifdef ADIA_PERF_CNT_EN
      if (cyc == 60) chk("perf_ops", 32'(op_count), 32'd3);
      if (cyc == 73) chk("perf_active", active_cycles, 32'd72);
`endif
      next();
      in_tag   = (cyc <= 16) ? 4'h2 : (cyc <= 32) ? 4'h3 : 4'h4;
      in_valid = (cyc <= 32) || (cyc >= 65 && cyc <= 73);
    end
    in_valid = 1'b0;

    // NSTAGES=1, PHASE_CYC=2 instance.
    rst1 = 1'b0; in_valid1 = 1'b1; in_tag1 = 4'h9; cyc = 0;
    chk("t5_ready0", 32'(in_ready1), 32'h1);
    next();
    in_valid1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("t5_oval", 32'(out_valid1), 32'(cyc == 4));
      if (cyc == 4) chk("t5_otag", 32'(out_tag1), 32'h9);
      if (cyc <= 8) begin
        chk("t5_code", 32'(pc_phase1), 32'((cyc - 1) / 2));
        chk("t5_en", 32'(pc_en1), 32'h1);
      end
      if (cyc == 8) chk("t5_ready8", 32'(in_ready1), 32'h1);
      if (cyc >= 9) begin
        chk("t5_idle_en", 32'(pc_en1), 32'h0);
        chk("t5_idle_ph", 32'(pc_phase1), 32'h3);
        chk("t5_idle_ready", 32'(in_ready1), 32'h1);
      end
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
